dbus_mem: RTL and testbench

DBUS_MEM -- requirements
Module: dbus_mem

---
 rtl/dbus_pkg.sv | 25 ++
 rtl/dbus_lane_align.sv | 57 +++++
 rtl/dbus_mem.sv | 131 +++++++++++++
 tb/tb_dbus_mem.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus family: access-mode encodings and the
// access FSM state type, reused by cache and pipeline blocks.
package dbus_pkg;

  // Access size/sign encodings carried on dbus_mode.
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Access FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dbus_state_e;

  // True for the five legal mode encodings.
  function automatic logic mode_valid(input logic [2:0] mode);
    return (mode == MODE_B) || (mode == MODE_H) || (mode == MODE_W) ||
           (mode == MODE_BU) || (mode == MODE_HU);
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational lane steering: write byte-enables and replicated store data,
// sign/zero-extended load data, and alignment / illegal-mode flags.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mode,
  input  logic [31:0] data_w,
  input  logic [31:0] word_r,
  output logic [3:0]  byte_en,
  output logic [31:0] data_w_sh,
  output logic [31:0] data_r_ext,
  output logic        misalign,
  output logic        mode_err
);

  logic [31:0] word_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Byte lane addr_lo moved down to bits [7:0]; half selected by addr_lo[1].
  assign word_shift = word_r >> {addr_lo, 3'b000};
  assign rd_byte    = word_shift[7:0];
  assign rd_half    = addr_lo[1] ? word_r[31:16] : word_r[15:0];

  // Decode mode into lane enables, steered store data and extended load data.
  always_comb begin
    byte_en    = 4'b0000;
    data_w_sh  = 32'h0;
    data_r_ext = 32'h0;
    misalign   = 1'b0;
    mode_err   = !mode_valid(mode);
    case (mode)
      MODE_B, MODE_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        data_w_sh  = {4{data_w[7:0]}};
        data_r_ext = (mode == MODE_B) ? {{24{rd_byte[7]}}, rd_byte}
                                      : {24'h0, rd_byte};
      end
      MODE_H, MODE_HU: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        data_w_sh  = {2{data_w[15:0]}};
        data_r_ext = (mode == MODE_H) ? {{16{rd_half[15]}}, rd_half}
                                      : {16'h0, rd_half};
        misalign   = addr_lo[0];
      end
      MODE_W: begin
        byte_en    = 4'b1111;
        data_w_sh  = data_w;
        data_r_ext = word_r;
        misalign   = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_mem.sv
// Wait-state data-bus memory. Handshake: a request is a level on dbus_read /
// dbus_write sampled only in IDLE; completion is a one-cycle dbus_ready pulse
// (with dbus_fault and dbus_data_r valid in that cycle); the initiator must
// drop or change the request the cycle after dbus_ready or it is re-issued.
module dbus_mem
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_w,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [2:0]  dbus_mode,
  output logic [31:0] dbus_data_r,
  output logic        dbus_ready,
  output logic        dbus_fault,
  output dbus_state_e dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dbus_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] req_addr, req_data;
  logic [2:0]  req_mode;
  logic        req_rd, req_wr;
  logic        fault_q;

  logic        accept, enter_done, commit;
  logic [31:0] cur_addr, cur_data;
  logic [2:0]  cur_mode;
  logic        cur_rd, cur_wr;
  logic [AW-1:0] word_idx;
  logic [31:0] word_r, data_w_sh, data_r_ext;
  logic [3:0]  byte_en;
  logic        misalign, mode_err, out_of_range, fault_c;

  assign accept = (state_q == IDLE) && (dbus_read || dbus_write);

  // With zero wait states the access completes on the accepting edge, so the
  // live inputs are used in IDLE and the latched copy afterwards.
  assign cur_addr = (state_q == IDLE) ? dbus_addr   : req_addr;
  assign cur_data = (state_q == IDLE) ? dbus_data_w : req_data;
  assign cur_mode = (state_q == IDLE) ? dbus_mode   : req_mode;
  assign cur_rd   = (state_q == IDLE) ? dbus_read   : req_rd;
  assign cur_wr   = (state_q == IDLE) ? dbus_write  : req_wr;

  assign word_idx     = cur_addr[AW+1:2];
  assign word_r       = mem[word_idx];
  assign out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign fault_c      = (cur_rd && cur_wr) || mode_err || misalign || out_of_range;

  assign enter_done = !reset && (state_d == DONE) && (state_q != DONE);
  assign commit     = enter_done && cur_wr && !fault_c;

  dbus_lane_align u_align (
    .addr_lo    (cur_addr[1:0]),
    .mode       (cur_mode),
    .data_w     (cur_data),
    .word_r     (word_r),
    .byte_en    (byte_en),
    .data_w_sh  (data_w_sh),
    .data_r_ext (data_r_ext),
    .misalign   (misalign),
    .mode_err   (mode_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, count down in WAIT, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dbus_read || dbus_write) state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      dbus_data_r <= 32'h0;
    end else begin
      fault_q <= 1'b0;
      if (accept) begin
        req_addr <= dbus_addr;
        req_data <= dbus_data_w;
        req_mode <= dbus_mode;
        req_rd   <= dbus_read;
        req_wr   <= dbus_write;
        cnt_q    <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (enter_done) begin
        fault_q     <= fault_c;
        dbus_data_r <= (fault_c || cur_wr) ? 32'h0 : data_r_ext;
      end
    end
  end

  // Backing storage: byte-lane store on the edge entering DONE; never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= data_w_sh[8*i +: 8];
      end
    end
  end

  assign dbus_ready = (state_q == DONE);
  assign dbus_fault = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dbus_mem.sv
// Bench for dbus_mem: one instance with one wait state and one with none.
// Drivers push expected {fault, data} and the cycle the response is due;
// per-instance monitors pop and compare whenever dbus_ready is seen.
module tb_dbus_mem;
  import dbus_pkg::*;

  // Clock and cycle count.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Instance with WAIT_CYCLES=1.
  logic        reset1, read1, write1, ready1, fault1;
  logic [2:0]  mode1;
  logic [31:0] addr1, wdata1, data_r1;
  dbus_state_e st1;

  // Instance with WAIT_CYCLES=0.
  logic        reset0, read0, write0, ready0, fault0;
  logic [2:0]  mode0;
  logic [31:0] addr0, wdata0, data_r0;
  dbus_state_e st0;

  dbus_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .dbus_addr(addr1), .dbus_data_w(wdata1),
    .dbus_read(read1), .dbus_write(write1), .dbus_mode(mode1),
    .dbus_data_r(data_r1), .dbus_ready(ready1), .dbus_fault(fault1),
    .dbg_state(st1)
  );

  dbus_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset0), .dbus_addr(addr0), .dbus_data_w(wdata0),
    .dbus_read(read0), .dbus_write(write0), .dbus_mode(mode0),
    .dbus_data_r(data_r0), .dbus_ready(ready0), .dbus_fault(fault0),
    .dbg_state(st0)
  );

  // Scoreboard queues: {fault, data} and due cycle.
  logic [32:0] exp1_q[$];
  int          cyc1_q[$];
  logic [32:0] exp0_q[$];
  int          cyc0_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor for the one-wait-state instance.
  logic [32:0] e1;
  int          c1;
  always @(negedge clk) begin
    if (started) begin
      if (ready1 === 1'b1) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w1_unexpected_ready actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e1 = exp1_q.pop_front();
          c1 = cyc1_q.pop_front();
          check("w1_data", data_r1, e1[31:0]);
          check("w1_fault", 32'(fault1), 32'(e1[32]));
          check("w1_latency", 32'(cyc), 32'(c1));
        end
      end else begin
        check("w1_fault_without_ready", 32'(fault1), 32'h0);
      end
    end
  end

  // Monitor for the zero-wait-state instance.
  logic [32:0] e0;
  int          c0;
  always @(negedge clk) begin
    if (started) begin
      if (ready0 === 1'b1) begin
        if (exp0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w0_unexpected_ready actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e0 = exp0_q.pop_front();
          c0 = cyc0_q.pop_front();
          check("w0_data", data_r0, e0[31:0]);
          check("w0_fault", 32'(fault0), 32'(e0[32]));
          check("w0_latency", 32'(cyc), 32'(c0));
        end
      end else begin
        check("w0_fault_without_ready", 32'(fault0), 32'h0);
      end
    end
  end

  // One access on the one-wait-state instance; response due 2 cycles after
  // acceptance. Afterwards the result must hold while idle.
  task automatic drive1(input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_f);
    read1 = rd; write1 = wr; mode1 = mode; addr1 = addr; wdata1 = wd;
    exp1_q.push_back({exp_f, exp_d});
    cyc1_q.push_back(cyc + 2);
    @(negedge clk);
    read1 = 1'b0; write1 = 1'b0;
    repeat (2) @(negedge clk);
    check("w1_hold_after_done", data_r1, exp_d);
  endtask

  // One request on the zero-wait-state instance held across three edges:
  // accepted at the first and third, so two identical responses every other cycle.
  task automatic drive0(input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d);
    read0 = rd; write0 = wr; mode0 = mode; addr0 = addr; wdata0 = wd;
    exp0_q.push_back({1'b0, exp_d});
    cyc0_q.push_back(cyc + 1);
    exp0_q.push_back({1'b0, exp_d});
    cyc0_q.push_back(cyc + 3);
    repeat (3) @(negedge clk);
    read0 = 1'b0; write0 = 1'b0;
    @(negedge clk);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset1 = 1'b1; read1 = 1'b0; write1 = 1'b0; mode1 = MODE_W; addr1 = '0; wdata1 = '0;
    reset0 = 1'b1; read0 = 1'b0; write0 = 1'b0; mode0 = MODE_W; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);

    check("rst_ready1",  32'(ready1), 32'h0);
    check("rst_fault1",  32'(fault1), 32'h0);
    check("rst_data_r1", data_r1, 32'h0);
    check("rst_state1",  32'(st1), 32'(IDLE));
    check("rst_ready0",  32'(ready0), 32'h0);
    check("rst_data_r0", data_r0, 32'h0);
    check("rst_state0",  32'(st0), 32'(IDLE));
    reset1 = 1'b0; reset0 = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Word store/load, byte store and extensions.
    drive1(1'b0, 1'b1, MODE_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    drive1(1'b1, 1'b0, MODE_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    drive1(1'b0, 1'b1, MODE_B,  32'h13, 32'h00000080, 32'h0,        1'b0);
    drive1(1'b1, 1'b0, MODE_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
    drive1(1'b1, 1'b0, MODE_BU, 32'h13, 32'h0,        32'h00000080, 1'b0);
    drive1(1'b1, 1'b0, MODE_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    drive1(1'b1, 1'b0, MODE_H,  32'h12, 32'h0,        32'hFFFF80AD, 1'b0);
    drive1(1'b1, 1'b0, MODE_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);

    // Faults: misaligned half, misaligned word store, read+write, range, mode.
    drive1(1'b1, 1'b0, MODE_H,  32'h11,   32'h0,        32'h0, 1'b1);
    drive1(1'b0, 1'b1, MODE_W,  32'h12,   32'h11111111, 32'h0, 1'b1);
    drive1(1'b1, 1'b0, MODE_W,  32'h10,   32'h0,        32'h80ADBEEF, 1'b0);
    drive1(1'b1, 1'b1, MODE_W,  32'h10,   32'h22222222, 32'h0, 1'b1);
    drive1(1'b1, 1'b0, MODE_W,  32'h10,   32'h0,        32'h80ADBEEF, 1'b0);
    drive1(1'b1, 1'b0, MODE_W,  32'h1000, 32'h0,        32'h0, 1'b1);
    drive1(1'b1, 1'b0, 3'b011,  32'h0,    32'h0,        32'h0, 1'b1);
    drive1(1'b1, 1'b0, 3'b110,  32'h10,   32'h0,        32'h0, 1'b1);

    // Reset in WAIT aborts a store; reset beats a request in IDLE.
    drive1(1'b0, 1'b1, MODE_W,  32'h20, 32'h12345678, 32'h0, 1'b0);
    read1 = 1'b0; write1 = 1'b1; mode1 = MODE_W; addr1 = 32'h20; wdata1 = 32'h1;
    @(negedge clk);
    check("accepted_into_wait", 32'(st1), 32'(WAIT));
    reset1 = 1'b1; write1 = 1'b0;
    @(negedge clk);
    check("rst_in_wait_ready", 32'(ready1), 32'h0);
    check("rst_in_wait_state", 32'(st1), 32'(IDLE));
    read1 = 1'b1;
    @(negedge clk);
    check("rst_priority_state", 32'(st1), 32'(IDLE));
    check("rst_priority_ready", 32'(ready1), 32'h0);
    reset1 = 1'b0; read1 = 1'b0;
    @(negedge clk);
    drive1(1'b1, 1'b0, MODE_W,  32'h20, 32'h0, 32'h12345678, 1'b0);

    // Zero wait states: held requests repeat every other cycle.
    drive0(1'b0, 1'b1, MODE_W,  32'h40, 32'hCAFEF00D, 32'h0);
    drive0(1'b1, 1'b0, MODE_W,  32'h40, 32'h0,        32'hCAFEF00D);
    drive0(1'b0, 1'b1, MODE_H,  32'h42, 32'h0000BEEF, 32'h0);
    drive0(1'b1, 1'b0, MODE_HU, 32'h42, 32'h0,        32'h0000BEEF);
    drive0(1'b1, 1'b0, MODE_H,  32'h42, 32'h0,        32'hFFFFBEEF);
    drive0(1'b1, 1'b0, MODE_W,  32'h40, 32'h0,        32'hBEEFF00D);

    // Drain: every expected response must have arrived.
    repeat (8) @(negedge clk);
    checks++;
    if (exp1_q.size() != 0) begin
      errors++;
      $display("FAIL w1_missing_responses actual=%0d required=0", exp1_q.size());
    end
    checks++;
    if (exp0_q.size() != 0) begin
      errors++;
      $display("FAIL w0_missing_responses actual=%0d required=0", exp0_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
